// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding
// and the legal ranges of the configuration parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 8;
  localparam int OVERSAMPLE_MIN = 2;
  localparam int OVERSAMPLE_MAX = 32;
  localparam int FIFO_DEPTH_MIN = 2;
  localparam int FIFO_DEPTH_MAX = 16;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  // True when v is a positive power of two
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // True when the FIFO depth is a power of two inside the supported range
  function automatic bit fifo_depth_legal(input int depth);
    return is_pow2(depth) && (depth >= FIFO_DEPTH_MIN) && (depth <= FIFO_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on rdata; a push is accepted whenever the FIFO is not full at the clock
// edge, regardless of whether a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap freely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter. Words are queued in a small FIFO and sent as
// start / data (LSB first) / optional parity / stop frames, each bit lasting
// OVERSAMPLE pulses of bd_tick. Back-to-back frames are sent with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          bd_tick,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_en,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_overflow,
  output logic                          uart_tx
);

  localparam int TW  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW  = 3;
  localparam bit ODD = (PARITY_ODD != 0);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..8");
  end
  if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX) begin : g_bad_oversample
    $error("uart_tx_fifo: OVERSAMPLE must be in 2..32");
  end
  if (!fifo_depth_legal(FIFO_DEPTH)) begin : g_bad_fifo_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
    $error("uart_tx_fifo: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  tx_state_t            state;
  tx_state_t            state_next;
  logic [TW-1:0]        tick_cnt;
  logic [TW-1:0]        tick_next;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 parity_bit;
  logic                 parity_next;
  logic                 line_next;
  logic                 start_frame;
  logic                 bit_done;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sysclk),
    .rst   (reset),
    .push  (tx_en),
    .pop   (start_frame),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state != IDLE) || !fifo_empty;
  assign bit_done = bd_tick && (tick_cnt == TW'(OVERSAMPLE - 1));

  // Next-state, counters and the next line level; a new frame is loaded from
  // the FIFO head whenever the line is free and a word is waiting
  always_comb begin
    state_next  = state;
    tick_next   = tick_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    parity_next = parity_bit;
    line_next   = uart_tx;
    start_frame = 1'b0;

    if (state != IDLE && bd_tick) begin
      tick_next = bit_done ? '0 : tick_cnt + TW'(1);
    end

    case (state)
      IDLE: begin
        line_next   = 1'b1;
        start_frame = !fifo_empty;
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          bit_next   = '0;
          line_next  = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_next = '0;
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              line_next  = parity_bit;
            end else begin
              state_next = STOP;
              line_next  = 1'b1;
            end
          end else begin
            bit_next   = bit_cnt + BW'(1);
            shift_next = shift_reg >> 1;
            line_next  = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          bit_next   = '0;
          line_next  = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_next = IDLE;
              line_next  = 1'b1;
            end
          end else begin
            bit_next = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        line_next  = 1'b1;
      end
    endcase

    if (start_frame) begin
      state_next  = START;
      tick_next   = '0;
      bit_next    = '0;
      shift_next  = fifo_rdata;
      parity_next = (^fifo_rdata) ^ ODD;
      line_next   = 1'b0;
    end
  end

  // Frame state, counters and the registered serial line
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      uart_tx    <= 1'b1;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      uart_tx    <= line_next;
    end
  end

  // One-cycle pulse flagging a write that arrived while the FIFO was full
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_overflow <= 1'b0;
    end else begin
      tx_overflow <= tx_en && fifo_full;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: three differently configured instances share
// one stimulus stream; each has a frame-level reference model and a line
// monitor that decodes frames and matches them against a scoreboard.
module tb_uart_tx_fifo;

  localparam int N = 3;
  localparam int DB_T [N] = '{8, 8, 5};
  localparam int PE_T [N] = '{0, 1, 1};
  localparam int PO_T [N] = '{0, 0, 1};
  localparam int SB_T [N] = '{1, 2, 1};
  localparam int OS_T [N] = '{16, 16, 3};
  localparam int DP_T [N] = '{4, 4, 2};

  logic       sysclk = 1'b0;
  logic       reset;
  logic       bd_tick;
  logic       tx_en;
  logic [7:0] tx_data;
  int         tick_mode;

  logic       ready_w [N];
  logic       busy_w  [N];
  logic       ovf_w   [N];
  logic       line_w  [N];
  int         cnt_w   [N];
  logic [2:0] cnt_a;
  logic [2:0] cnt_b;
  logic [1:0] cnt_c;

  int tests = 0;
  int fails = 0;
  event end_ev;

  assign cnt_w[0] = int'(cnt_a);
  assign cnt_w[1] = int'(cnt_b);
  assign cnt_w[2] = int'(cnt_c);

  always #5 sysclk = ~sysclk;

  uart_tx_fifo u_dut_a (
    .sysclk(sysclk), .reset(reset), .bd_tick(bd_tick), .tx_data(tx_data),
    .tx_en(tx_en), .tx_ready(ready_w[0]), .tx_busy(busy_w[0]),
    .fifo_count(cnt_a), .tx_overflow(ovf_w[0]), .uart_tx(line_w[0])
  );

  uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_b (
    .sysclk(sysclk), .reset(reset), .bd_tick(bd_tick), .tx_data(tx_data),
    .tx_en(tx_en), .tx_ready(ready_w[1]), .tx_busy(busy_w[1]),
    .fifo_count(cnt_b), .tx_overflow(ovf_w[1]), .uart_tx(line_w[1])
  );

  uart_tx_fifo #(.DATA_BITS(5), .OVERSAMPLE(3), .FIFO_DEPTH(2),
                 .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut_c (
    .sysclk(sysclk), .reset(reset), .bd_tick(bd_tick), .tx_data(tx_data[4:0]),
    .tx_en(tx_en), .tx_ready(ready_w[2]), .tx_busy(busy_w[2]),
    .fifo_count(cnt_c), .tx_overflow(ovf_w[2]), .uart_tx(line_w[2])
  );

  // Compare one observed value against its expected value
  task automatic check_output(input string name, input int idx, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s dut%0d: actual=%0d required=%0d t=%0t", name, idx, actual, expected, $time);
    end
  endtask

  // Bit sequence of one frame, index 0 first on the line, unused positions high
  function automatic logic [15:0] frame_of(input logic [7:0] w, input int db, input int pe,
                                           input int po, input int sb);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1 + i] = w[i];
      ones += int'(w[i]);
    end
    if (pe != 0) f[1 + db] = ((ones % 2) != po);
    for (int i = 0; i < sb; i++) f[1 + db + pe + i] = 1'b1;
    return f;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_chk
    localparam int DB    = DB_T[g];
    localparam int PE    = PE_T[g];
    localparam int PO    = PO_T[g];
    localparam int SB    = SB_T[g];
    localparam int OS    = OS_T[g];
    localparam int DP    = DP_T[g];
    localparam int NBITS = 1 + DB + PE + SB;
    localparam int FT    = NBITS * OS;

    logic [7:0]  q  [$];
    logic [7:0]  sb [$];
    bit          active  = 0;
    int          elapsed = 0;
    logic [15:0] vec     = '1;
    bit          ovf_exp = 0;
    bit          m_active = 0;
    int          m_ticks  = 0;
    logic [15:0] m_bits   = '1;

    // Reference model: a word waits in the queue until the line is free,
    // then occupies the line for FT bd_tick pulses
    always @(posedge sysclk) begin : model
      int pre;
      bit full;
      bit ending;
      bit do_pop;
      logic [7:0] w;
      if (reset) begin
        q.delete();
        sb.delete();
        active  = 0;
        elapsed = 0;
        ovf_exp = 0;
      end else begin
        pre    = q.size();
        full   = (pre == DP);
        ending = active && bd_tick && (elapsed == FT - 1);
        do_pop = (pre > 0) && (!active || ending);
        if (active && bd_tick) begin
          elapsed++;
          if (ending) active = 0;
        end
        if (do_pop) begin
          w       = q.pop_front();
          active  = 1;
          elapsed = 0;
          vec     = frame_of(w, DB, PE, PO, SB);
        end
        ovf_exp = tx_en && full;
        if (tx_en && !full) begin
          w = tx_data & 8'((1 << DB) - 1);
          q.push_back(w);
          sb.push_back(w);
        end
      end
    end

    // Cycle checks of the status outputs and line level against the model
    always @(negedge sysclk) begin : cycle_check
      int e_line, e_cnt, e_ready, e_busy, e_ovf;
      if (reset) begin
        e_line = 1; e_cnt = 0; e_ready = 1; e_busy = 0; e_ovf = 0;
      end else begin
        e_line  = active ? int'(vec[elapsed / OS]) : 1;
        e_cnt   = q.size();
        e_ready = (q.size() < DP) ? 1 : 0;
        e_busy  = (active || q.size() > 0) ? 1 : 0;
        e_ovf   = int'(ovf_exp);
      end
      check_output("uart_tx", g, int'(line_w[g]), e_line);
      check_output("fifo_count", g, cnt_w[g], e_cnt);
      check_output("tx_ready", g, int'(ready_w[g]), e_ready);
      check_output("tx_busy", g, int'(busy_w[g]), e_busy);
      check_output("tx_overflow", g, int'(ovf_w[g]), e_ovf);
    end

    // Line monitor: decodes frames by sampling mid-bit, then pops the
    // scoreboard and compares the whole bit sequence
    always @(negedge sysclk) begin : monitor
      logic [7:0] w;
      if (reset) begin
        m_active = 0;
      end else begin
        if (!m_active && line_w[g] == 1'b0) begin
          m_active = 1;
          m_ticks  = 0;
          m_bits   = '1;
        end
        if (m_active) begin
          if (m_ticks % OS == OS / 2) m_bits[m_ticks / OS] = line_w[g];
          if (bd_tick) begin
            m_ticks++;
            if (m_ticks == FT) begin
              m_active = 0;
              if (sb.size() == 0) begin
                check_output("frame_expected", g, 0, 1);
              end else begin
                w = sb.pop_front();
                check_output("frame_bits", g, int'(m_bits), int'(frame_of(w, DB, PE, PO, SB)));
              end
            end
          end
        end
      end
    end

    // Every accepted word must have appeared on the line by the end
    always @(end_ev) begin
      check_output("scoreboard_empty", g, sb.size(), 0);
    end
  end

  // bd_tick generator: every cycle, every 4th cycle, or random
  initial begin
    int ph;
    ph = 0;
    bd_tick = 1'b1;
    forever begin
      @(posedge sysclk);
      #1;
      ph++;
      case (tick_mode)
        0:       bd_tick = 1'b1;
        1:       bd_tick = (ph % 4 == 0);
        default: bd_tick = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Present one word for exactly one clock edge
  task automatic apply_stimulus(input logic [7:0] d);
    tx_en   = 1'b1;
    tx_data = d;
    @(posedge sysclk);
    #1;
    tx_en   = 1'b0;
    tx_data = 8'($urandom);
  endtask

  // Wait until every instance has finished transmitting, bounded
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_w[0] || busy_w[1] || busy_w[2]) && n < budget) begin
      @(posedge sysclk);
      #1;
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("[TB] FAIL drain_timeout: actual=%0d cycles required<%0d", n, budget);
    end
  endtask

  initial begin
    reset     = 1'b1;
    tx_en     = 1'b0;
    tx_data   = 8'h00;
    tick_mode = 0;
    repeat (3) @(posedge sysclk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;

    apply_stimulus(8'h55);
    wait_idle(2000);
    apply_stimulus(8'h07);
    wait_idle(2000);

    for (int i = 0; i < 6; i++) apply_stimulus(8'($urandom));
    wait_idle(6000);

    for (int off = -1; off <= 1; off++) begin
      apply_stimulus(8'($urandom));
      repeat (160 + off) @(posedge sysclk);
      #1;
      apply_stimulus(8'hA3);
      wait_idle(3000);
    end

    apply_stimulus(8'hC6);
    repeat (70) @(posedge sysclk);
    #1;
    reset = 1'b1;
    tx_en = 1'b1;
    #1;
    check_output("reset_line", 0, int'(line_w[0]), 1);
    check_output("reset_count", 0, cnt_w[0], 0);
    repeat (3) @(posedge sysclk);
    #1;
    reset = 1'b0;
    tx_en = 1'b0;
    repeat (60) @(posedge sysclk);
    #1;

    tick_mode = 1;
    apply_stimulus(8'h3C);
    apply_stimulus(8'($urandom));
    wait_idle(6000);

    tick_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      tx_en   = ($urandom_range(0, 39) == 0);
      tx_data = 8'($urandom);
      if (i == 2500) reset = 1'b1;
      if (i == 2503) reset = 1'b0;
      @(posedge sysclk);
      #1;
    end
    tx_en = 1'b0;
    wait_idle(20000);

    -> end_ev;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
